reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 220 ++++++++++++++++++++++
 tb/tb_reservation_station.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ALU ops until both operands are
// ready, snooping the result broadcast, and issues the lowest ready slot.
module reservation_station #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [3:0]       dispatch_alu_control,
    input  logic             dispatch_alu_src,
    input  logic             dispatch_is_for_lsq,
    input  logic [31:0]      dispatch_imm,
    input  logic             dispatch_rs1_ready,
    input  logic             dispatch_rs2_ready,
    input  logic [5:0]       dispatch_rs1_tag,
    input  logic [5:0]       dispatch_rs2_tag,
    input  logic [31:0]      dispatch_rs1_value,
    input  logic [31:0]      dispatch_rs2_value,
    input  logic [5:0]       dispatch_dest_tag,
    input  logic [5:0]       dispatch_rob_index,
    input  logic             wakeup_active,
    input  logic [5:0]       wakeup_tag,
    input  logic [31:0]      wakeup_value,
    input  logic             fu_available,
    output logic             issue_valid,
    output logic [3:0]       issue_alu_control,
    output logic             issue_alu_src,
    output logic             issue_is_for_lsq,
    output logic [31:0]      issue_imm,
    output logic [31:0]      issue_rs1_value,
    output logic [31:0]      issue_rs2_value,
    output logic [5:0]       issue_tag,
    output logic [5:0]       issue_rob_index,
    output logic [CNT_W-1:0] occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_rs1_ready;
    logic [DEPTH-1:0] ent_rs2_ready;
    logic [5:0]       ent_rs1_tag     [DEPTH];
    logic [5:0]       ent_rs2_tag     [DEPTH];
    logic [31:0]      ent_rs1_value   [DEPTH];
    logic [31:0]      ent_rs2_value   [DEPTH];
    logic [3:0]       ent_alu_control [DEPTH];
    logic             ent_alu_src     [DEPTH];
    logic             ent_is_for_lsq  [DEPTH];
    logic [31:0]      ent_imm         [DEPTH];
    logic [5:0]       ent_dest_tag    [DEPTH];
    logic [5:0]       ent_rob_index   [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             dispatch_fire;

    logic             new_rs1_ready;
    logic [31:0]      new_rs1_value;
    logic             new_rs2_ready;
    logic [31:0]      new_rs2_value;

    assign eligible       = ent_valid & ent_rs1_ready & ent_rs2_ready;
    assign dispatch_ready = ({1'b0, occupancy} < (CNT_W+1)'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready && free_found;

    // Lowest-index free slot receives the next dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index entry with both operands ready is the issue candidate.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Operand capture at dispatch, including same-cycle broadcast bypass.
    always_comb begin
        new_rs1_ready = dispatch_rs1_ready;
        new_rs1_value = dispatch_rs1_value;
        if (!dispatch_rs1_ready && wakeup_active
            && (wakeup_tag == dispatch_rs1_tag)) begin
            new_rs1_ready = 1'b1;
            new_rs1_value = wakeup_value;
        end
        new_rs2_ready = dispatch_rs2_ready;
        new_rs2_value = dispatch_rs2_value;
        if (dispatch_alu_src) begin
            new_rs2_ready = 1'b1;
        end else if (!dispatch_rs2_ready && wakeup_active
                     && (wakeup_tag == dispatch_rs2_tag)) begin
            new_rs2_ready = 1'b1;
            new_rs2_value = wakeup_value;
        end
    end

    // Issue port: fields of the selected entry, forced to zero when idle.
    always_comb begin
        issue_valid       = fu_available && sel_found;
        issue_alu_control = '0;
        issue_alu_src     = 1'b0;
        issue_is_for_lsq  = 1'b0;
        issue_imm         = '0;
        issue_rs1_value   = '0;
        issue_rs2_value   = '0;
        issue_tag         = '0;
        issue_rob_index   = '0;
        if (issue_valid) begin
            issue_alu_control = ent_alu_control[sel_idx];
            issue_alu_src     = ent_alu_src[sel_idx];
            issue_is_for_lsq  = ent_is_for_lsq[sel_idx];
            issue_imm         = ent_imm[sel_idx];
            issue_rs1_value   = ent_rs1_value[sel_idx];
            issue_rs2_value   = ent_rs2_value[sel_idx];
            issue_tag         = ent_dest_tag[sel_idx];
            issue_rob_index   = ent_rob_index[sel_idx];
        end
    end

    // Entry status, operand wakeup, issue invalidation and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid     <= '0;
            ent_rs1_ready <= '0;
            ent_rs2_ready <= '0;
            occupancy     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rs1_tag[i]   <= '0;
                ent_rs2_tag[i]   <= '0;
                ent_rs1_value[i] <= '0;
                ent_rs2_value[i] <= '0;
            end
        end else if (flush) begin
            ent_valid     <= '0;
            ent_rs1_ready <= '0;
            ent_rs2_ready <= '0;
            occupancy     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wakeup_active && ent_valid[i]) begin
                    if (!ent_rs1_ready[i]
                        && (ent_rs1_tag[i] == wakeup_tag)) begin
                        ent_rs1_ready[i] <= 1'b1;
                        ent_rs1_value[i] <= wakeup_value;
                    end
                    if (!ent_rs2_ready[i]
                        && (ent_rs2_tag[i] == wakeup_tag)) begin
                        ent_rs2_ready[i] <= 1'b1;
                        ent_rs2_value[i] <= wakeup_value;
                    end
                end
            end
            if (issue_valid) begin
                ent_valid[sel_idx] <= 1'b0;
            end
            if (dispatch_fire) begin
                ent_valid[free_idx]     <= 1'b1;
                ent_rs1_ready[free_idx] <= new_rs1_ready;
                ent_rs2_ready[free_idx] <= new_rs2_ready;
                ent_rs1_tag[free_idx]   <= dispatch_rs1_tag;
                ent_rs2_tag[free_idx]   <= dispatch_rs2_tag;
                ent_rs1_value[free_idx] <= new_rs1_value;
                ent_rs2_value[free_idx] <= new_rs2_value;
            end
            occupancy <= occupancy + CNT_W'(dispatch_fire)
                         - CNT_W'(issue_valid);
        end
    end

    // Static instruction fields, written only when a slot is allocated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_alu_control[i] <= '0;
                ent_alu_src[i]     <= 1'b0;
                ent_is_for_lsq[i]  <= 1'b0;
                ent_imm[i]         <= '0;
                ent_dest_tag[i]    <= '0;
                ent_rob_index[i]   <= '0;
            end
        end else if (dispatch_fire && !flush) begin
            ent_alu_control[free_idx] <= dispatch_alu_control;
            ent_alu_src[free_idx]     <= dispatch_alu_src;
            ent_is_for_lsq[free_idx]  <= dispatch_is_for_lsq;
            ent_imm[free_idx]         <= dispatch_imm;
            ent_dest_tag[free_idx]    <= dispatch_dest_tag;
            ent_rob_index[free_idx]   <= dispatch_rob_index;
        end
    end

    // Upstream must never present an instruction while the station is full.
    assert property (@(posedge clk) disable iff (reset)
        !(dispatch_valid && !dispatch_ready))
    else $fatal(1, "dispatch attempted while station full");

    // Occupancy can never exceed the number of physical entries.
    assert property (@(posedge clk) disable iff (reset)
        ({1'b0, occupancy} <= (CNT_W+1)'(DEPTH)))
    else $fatal(1, "occupancy above depth");

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, corner sequences,
// and randomized traffic against a slot-level behavioural model.
module tb_reservation_station;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [3:0]  dispatch_alu_control;
    logic        dispatch_alu_src;
    logic        dispatch_is_for_lsq;
    logic [31:0] dispatch_imm;
    logic        dispatch_rs1_ready;
    logic        dispatch_rs2_ready;
    logic [5:0]  dispatch_rs1_tag;
    logic [5:0]  dispatch_rs2_tag;
    logic [31:0] dispatch_rs1_value;
    logic [31:0] dispatch_rs2_value;
    logic [5:0]  dispatch_dest_tag;
    logic [5:0]  dispatch_rob_index;
    logic        wakeup_active;
    logic [5:0]  wakeup_tag;
    logic [31:0] wakeup_value;
    logic        fu_available;
    logic        issue_valid;
    logic [3:0]  issue_alu_control;
    logic        issue_alu_src;
    logic        issue_is_for_lsq;
    logic [31:0] issue_imm;
    logic [31:0] issue_rs1_value;
    logic [31:0] issue_rs2_value;
    logic [5:0]  issue_tag;
    logic [5:0]  issue_rob_index;
    logic [CNT_W-1:0] occupancy;

    reservation_station #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_alu_control(dispatch_alu_control),
        .dispatch_alu_src(dispatch_alu_src),
        .dispatch_is_for_lsq(dispatch_is_for_lsq),
        .dispatch_imm(dispatch_imm),
        .dispatch_rs1_ready(dispatch_rs1_ready),
        .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_tag(dispatch_rs1_tag),
        .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_value(dispatch_rs1_value),
        .dispatch_rs2_value(dispatch_rs2_value),
        .dispatch_dest_tag(dispatch_dest_tag),
        .dispatch_rob_index(dispatch_rob_index),
        .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag),
        .wakeup_value(wakeup_value), .fu_available(fu_available),
        .issue_valid(issue_valid), .issue_alu_control(issue_alu_control),
        .issue_alu_src(issue_alu_src), .issue_is_for_lsq(issue_is_for_lsq),
        .issue_imm(issue_imm), .issue_rs1_value(issue_rs1_value),
        .issue_rs2_value(issue_rs2_value), .issue_tag(issue_tag),
        .issue_rob_index(issue_rob_index), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        r1;
        logic        r2;
        logic [5:0]  t1;
        logic [5:0]  t2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  ctrl;
        logic        src;
        logic        lsq;
        logic [31:0] imm;
        logic [5:0]  dtag;
        logic [5:0]  rob;
    } ent_t;

    typedef struct {
        logic        dv;
        logic        src;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [5:0]  t2;
        logic [31:0] v2;
        logic [5:0]  dtag;
        logic        wa;
        logic [5:0]  wt;
        logic [31:0] wv;
        logic        fu;
        logic        e_iv;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic [5:0]  e_tag;
        logic [3:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    ent_t m [DEPTH];
    int   mocc;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [14];

    function automatic vec_t mkv(
        logic dv, logic src,
        logic r1, logic [5:0] t1, logic [31:0] v1,
        logic r2, logic [5:0] t2, logic [31:0] v2,
        logic [5:0] dtag,
        logic wa, logic [5:0] wt, logic [31:0] wv,
        logic fu,
        logic e_iv, logic [31:0] e_v1, logic [31:0] e_v2,
        logic [5:0] e_tag, logic [3:0] e_occ, logic e_rdy);
        vec_t v;
        v.dv = dv; v.src = src;
        v.r1 = r1; v.t1 = t1; v.v1 = v1;
        v.r2 = r2; v.t2 = t2; v.v2 = v2;
        v.dtag = dtag;
        v.wa = wa; v.wt = wt; v.wv = wv;
        v.fu = fu;
        v.e_iv = e_iv; v.e_v1 = e_v1; v.e_v2 = e_v2;
        v.e_tag = e_tag; v.e_occ = e_occ; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act,
                         logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush                = 1'b0;
        dispatch_valid       = 1'b0;
        dispatch_alu_control = '0;
        dispatch_alu_src     = 1'b0;
        dispatch_is_for_lsq  = 1'b0;
        dispatch_imm         = '0;
        dispatch_rs1_ready   = 1'b0;
        dispatch_rs2_ready   = 1'b0;
        dispatch_rs1_tag     = '0;
        dispatch_rs2_tag     = '0;
        dispatch_rs1_value   = '0;
        dispatch_rs2_value   = '0;
        dispatch_dest_tag    = '0;
        dispatch_rob_index   = '0;
        wakeup_active        = 1'b0;
        wakeup_tag           = '0;
        wakeup_value         = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m[i].vld = 1'b0;
            m[i].r1  = 1'b0;
            m[i].r2  = 1'b0;
        end
        mocc = 0;
    endtask

    function automatic int pick();
        for (int i = 0; i < DEPTH; i++)
            if (m[i].vld && m[i].r1 && m[i].r2) return i;
        return -1;
    endfunction

    task automatic check_model(string name);
        int s;
        logic iv;
        logic [127:0] exp;
        logic [127:0] act;
        s  = pick();
        iv = fu_available && (s >= 0);
        check({name, ".issue_valid"}, 128'(issue_valid), 128'(iv));
        check({name, ".ready"}, 128'(dispatch_ready),
              128'(mocc < DEPTH));
        check({name, ".occupancy"}, 128'(occupancy), 128'(mocc));
        exp = '0;
        if (iv)
            exp = 128'({m[s].ctrl, m[s].src, m[s].lsq, m[s].imm,
                        m[s].v1, m[s].v2, m[s].dtag, m[s].rob});
        act = 128'({issue_alu_control, issue_alu_src, issue_is_for_lsq,
                    issue_imm, issue_rs1_value, issue_rs2_value,
                    issue_tag, issue_rob_index});
        check({name, ".issue_fields"}, act, exp);
    endtask

    task automatic model_step();
        int   s;
        int   f;
        logic ifire;
        logic dfire;
        ent_t n;
        s     = pick();
        ifire = fu_available && (s >= 0);
        if (flush) begin
            model_clear();
            return;
        end
        f = -1;
        for (int i = 0; i < DEPTH; i++)
            if (f < 0 && !m[i].vld) f = i;
        dfire = dispatch_valid && (mocc < DEPTH);
        if (wakeup_active) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].vld && !m[i].r1 && m[i].t1 == wakeup_tag) begin
                    m[i].r1 = 1'b1;
                    m[i].v1 = wakeup_value;
                end
                if (m[i].vld && !m[i].r2 && m[i].t2 == wakeup_tag) begin
                    m[i].r2 = 1'b1;
                    m[i].v2 = wakeup_value;
                end
            end
        end
        if (ifire) m[s].vld = 1'b0;
        if (dfire && f >= 0) begin
            n.vld  = 1'b1;
            n.ctrl = dispatch_alu_control;
            n.src  = dispatch_alu_src;
            n.lsq  = dispatch_is_for_lsq;
            n.imm  = dispatch_imm;
            n.dtag = dispatch_dest_tag;
            n.rob  = dispatch_rob_index;
            n.t1   = dispatch_rs1_tag;
            n.t2   = dispatch_rs2_tag;
            n.r1   = dispatch_rs1_ready;
            n.v1   = dispatch_rs1_value;
            if (!n.r1 && wakeup_active && wakeup_tag == n.t1) begin
                n.r1 = 1'b1;
                n.v1 = wakeup_value;
            end
            n.r2 = dispatch_rs2_ready;
            n.v2 = dispatch_rs2_value;
            if (dispatch_alu_src) begin
                n.r2 = 1'b1;
            end else if (!n.r2 && wakeup_active && wakeup_tag == n.t2) begin
                n.r2 = 1'b1;
                n.v2 = wakeup_value;
            end
            m[f] = n;
        end
        mocc = mocc + int'(dfire) - int'(ifire);
    endtask

    task automatic finish_cycle(string name);
        check_model(name);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(string name);
        #1;
        finish_cycle(name);
    endtask

    task automatic disp_ready_op(logic [31:0] a, logic [31:0] b,
                                 logic [5:0] dtag);
        idle_inputs();
        dispatch_valid       = 1'b1;
        dispatch_alu_control = dtag[3:0];
        dispatch_imm         = 32'h5000 + 32'(dtag);
        dispatch_rs1_ready   = 1'b1;
        dispatch_rs2_ready   = 1'b1;
        dispatch_rs1_value   = a;
        dispatch_rs2_value   = b;
        dispatch_dest_tag    = dtag;
        dispatch_rob_index   = dtag + 6'd1;
    endtask

    initial begin
        vecs[0]  = mkv(1,0, 1,0,5, 1,0,7, 3, 0,0,0, 1, 0,0,0,0, 0,1);
        vecs[1]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 1,5,7,3, 1,1);
        vecs[2]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 0,0,0,0, 0,1);
        vecs[3]  = mkv(1,0, 0,9,0, 1,0,2, 5, 0,0,0, 1, 0,0,0,0, 0,1);
        vecs[4]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 0,0,0,0, 1,1);
        vecs[5]  = mkv(0,0, 0,0,0, 0,0,0, 0, 1,9,32'h10, 1,
                       0,0,0,0, 1,1);
        vecs[6]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,
                       1,32'h10,2,5, 1,1);
        vecs[7]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 0,0,0,0, 0,1);
        vecs[8]  = mkv(1,0, 0,4,0, 1,0,1, 6, 1,4,32'hAA, 1,
                       0,0,0,0, 0,1);
        vecs[9]  = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,
                       1,32'hAA,1,6, 1,1);
        vecs[10] = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 0,0,0,0, 0,1);
        vecs[11] = mkv(1,1, 1,0,32'h33, 0,12,0, 7, 0,0,0, 1,
                       0,0,0,0, 0,1);
        vecs[12] = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,
                       1,32'h33,0,7, 1,1);
        vecs[13] = mkv(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1, 0,0,0,0, 0,1);

        reset = 1'b1;
        idle_inputs();
        fu_available = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            idle_inputs();
            dispatch_valid       = vecs[k].dv;
            dispatch_alu_src     = vecs[k].src;
            dispatch_alu_control = 4'(k);
            dispatch_is_for_lsq  = k[0];
            dispatch_imm         = 32'h1000 + 32'(k);
            dispatch_rob_index   = 6'(k + 32);
            dispatch_rs1_ready   = vecs[k].r1;
            dispatch_rs1_tag     = vecs[k].t1;
            dispatch_rs1_value   = vecs[k].v1;
            dispatch_rs2_ready   = vecs[k].r2;
            dispatch_rs2_tag     = vecs[k].t2;
            dispatch_rs2_value   = vecs[k].v2;
            dispatch_dest_tag    = vecs[k].dtag;
            wakeup_active        = vecs[k].wa;
            wakeup_tag           = vecs[k].wt;
            wakeup_value         = vecs[k].wv;
            fu_available         = vecs[k].fu;
            #1;
            check("vec.issue_valid", 128'(issue_valid),
                  128'(vecs[k].e_iv));
            check("vec.rs1_value", 128'(issue_rs1_value),
                  128'(vecs[k].e_v1));
            check("vec.rs2_value", 128'(issue_rs2_value),
                  128'(vecs[k].e_v2));
            check("vec.tag", 128'(issue_tag), 128'(vecs[k].e_tag));
            check("vec.occupancy", 128'(occupancy), 128'(vecs[k].e_occ));
            check("vec.ready", 128'(dispatch_ready), 128'(vecs[k].e_rdy));
            finish_cycle("vec");
        end

        fu_available = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            disp_ready_op(32'(k), 32'(100 + k), 6'(20 + k));
            tick("fill");
        end
        idle_inputs();
        #1;
        check("full.ready", 128'(dispatch_ready), 128'(0));
        check("full.occupancy", 128'(occupancy), 128'(8));
        check("full.no_issue", 128'(issue_valid), 128'(0));
        finish_cycle("full");
        fu_available = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("drain.issue_valid", 128'(issue_valid), 128'(1));
            check("drain.order", 128'(issue_tag), 128'(20 + k));
            check("drain.occupancy", 128'(occupancy), 128'(8 - k));
            finish_cycle("drain");
        end
        tick("drained");

        fu_available = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp_ready_op(32'(k + 1), 32'(k + 2), 6'(40 + k));
            tick("pre_flush");
        end
        disp_ready_op(32'h77, 32'h88, 6'd50);
        flush        = 1'b1;
        fu_available = 1'b1;
        #1;
        check("flush.pre_occupancy", 128'(occupancy), 128'(4));
        check("flush.comb_issue", 128'(issue_valid), 128'(1));
        finish_cycle("flush");
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_flush.occupancy", 128'(occupancy), 128'(0));
            check("post_flush.ready", 128'(dispatch_ready), 128'(1));
            check("post_flush.issue", 128'(issue_valid), 128'(0));
            finish_cycle("post_flush");
        end

        fu_available = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp_ready_op(32'(k + 9), 32'(k + 3), 6'(44 + k));
            if (k[0]) begin
                dispatch_rs1_ready = 1'b0;
                dispatch_rs1_tag   = 6'd30;
            end
            tick("pre_reset");
        end
        idle_inputs();
        fu_available = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("reset_mid.occupancy", 128'(occupancy), 128'(0));
        check("reset_mid.ready", 128'(dispatch_ready), 128'(1));
        check("reset_mid.issue", 128'(issue_valid), 128'(0));
        check("reset_mid.fields", 128'({issue_rs1_value, issue_tag}),
              128'(0));
        @(negedge clk);
        reset = 1'b0;
        wakeup_active = 1'b1;
        wakeup_tag    = 6'd30;
        wakeup_value  = 32'h55;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_reset.issue", 128'(issue_valid), 128'(0));
            finish_cycle("post_reset");
        end

        for (int c = 0; c < 2000; c++) begin
            idle_inputs();
            fu_available = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 63) == 0);
            if (mocc < DEPTH && dispatch_ready
                && $urandom_range(0, 1) == 1) begin
                dispatch_valid       = 1'b1;
                dispatch_alu_control = 4'($urandom);
                dispatch_alu_src     = ($urandom_range(0, 3) == 0);
                dispatch_is_for_lsq  = 1'($urandom);
                dispatch_imm         = $urandom;
                dispatch_rs1_ready   = ($urandom_range(0, 2) == 0);
                dispatch_rs2_ready   = ($urandom_range(0, 2) == 0);
                dispatch_rs1_tag     = 6'($urandom_range(0, 7));
                dispatch_rs2_tag     = 6'($urandom_range(0, 7));
                dispatch_rs1_value   = $urandom;
                dispatch_rs2_value   = $urandom;
                dispatch_dest_tag    = 6'($urandom);
                dispatch_rob_index   = 6'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                wakeup_active = 1'b1;
                wakeup_tag    = 6'($urandom_range(0, 7));
                wakeup_value  = $urandom;
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
